mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous memory (MemLPM, 32x16) between the multicycle
//  processor (port P) and a debug/loader port (port D, driven from switches/keys).
//  Round-robin arbitration, one transaction at a time, fixed 3-cycle issue period.
//  Sits between the requesters and MemLPM in the board top level.
//  Owner and Busy go to LEDs.
// PARAMETERS
//  AW  5   address width (memory depth 2**AW words)
//  DW  16  data width
// PORTS
//  Clock     in   1   system clock; every register updates on its rising edge
//  Reset     in   1   synchronous, active-high reset
//  P_Req     in   1   processor request; held high until P_Gnt is seen
//  P_Write   in   1   1 = write, 0 = read; stable while P_Req is high
//  P_Addr    in   AW  processor address; stable while P_Req is high
//  P_Data    in   DW  processor write data; stable while P_Req is high
//  P_Gnt     out  1   one-cycle pulse: the P request has been accepted
//  P_Valid   out  1   one-cycle pulse: the P transaction is complete
//  P_RData   out  DW  P read data; valid when P_Valid is high
//  D_Req, D_Write, D_Addr, D_Data, D_Gnt, D_Valid, D_RData
//                     debug port; same directions, widths and rules as the P port
//  Mem_Addr  out  AW  address to MemLPM
//  Mem_Data  out  DW  write data to MemLPM
//  Mem_Wren  out  1   write enable to MemLPM
//  Mem_Q     in   DW  MemLPM output; valid the cycle after the address edge
//  Busy      out  1   high when the state is not IDLE
//  Owner     out  1   current or last owner: 0 = P, 1 = D
// BEHAVIOUR
//  Reset values (next edge with Reset=1)
//   - All outputs are 0.
//   - State = IDLE.
//   - LastOwner = D, so P wins the first simultaneous request.
//   - Latched request registers are cleared.
//  States: IDLE -> ISSUE -> WAIT -> IDLE. Reset overrides every transition.
//  IDLE
//   - No request: stay in IDLE.
//   - Only one requester: it wins.
//   - Both requesting: the winner is the port that is not LastOwner.
//   - On a win: latch the winner's Write/Addr/Data, update Owner and LastOwner,
//     go to ISSUE, and register the winner's Gnt.
//  ISSUE
//   - Winner's Gnt = 1 for exactly this cycle.
//   - Mem_Addr and Mem_Data are driven from the latched values (registered).
//   - Mem_Wren = latched Write, in this cycle only.
//   - The memory samples at the end of ISSUE.
//  WAIT
//   - Mem_Wren = 0.
//   - Read: Mem_Q is captured into the owner's RData at the end of WAIT.
//   - Write: the owner's RData is left unchanged.
//   - Next state is IDLE; the owner's Valid is registered.
//  Valid and throughput
//   - Valid = 1 in the first IDLE cycle after WAIT, for reads and writes (write ack).
//   - That IDLE cycle can already arbitrate a new request.
//   - Timing: Req seen in IDLE at T; Gnt at T+1; Valid/RData at T+3.
//   - Sustained rate: one transaction per 3 cycles.
//  Request handling
//   - A Req still high in the IDLE cycle after its Gnt counts as a new request.
//   - Requesters drop Req in the cycle after Gnt to avoid a repeat.
//   - Req changing while the arbiter is busy: ignored until IDLE; requests are
//     never queued.
//   - The loser of a tie keeps Req high and is served in the next IDLE
//     (no starvation).
//  Other rules
//   - Addresses are AW bits and cover all 2**AW words; no range check is needed.
//   - P_RData and D_RData hold their values between reads.
//   - Reset during ISSUE or WAIT: Mem_Wren, Gnt and Valid are 0 from the next
//     cycle and the pending transaction is discarded. A write whose ISSUE edge
//     coincides with Reset may or may not reach memory.
// TESTING
//  1. Hold Reset 2 cycles -> all outputs 0, Busy=0, Owner=0.
//  2. P write A=5, D=16'hA5A5, then P read A=5 -> P_Gnt at T+1, P_Valid at T+3,
//     P_RData=16'hA5A5.
//  3. P_Req and D_Req rise together after reset -> P_Gnt at T+1, D_Gnt at T+4;
//     Owner 0 then 1.
//  4. Both Req held high for 12 cycles -> grants alternate P,D,P,D, one every
//     3 cycles; Mem_Wren high only in ISSUE cycles.
//  5. D write A=31, D=16'h1234, then P read A=31 -> P_RData=16'h1234 (top address).
//  6. Reset asserted in the ISSUE cycle of a P write -> next cycle Mem_Wren=0,
//     no P_Valid, Busy=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//  Bundles the two requester ports (P = processor, D = debug/loader), the
//  single-port memory connection and the status outputs of mem_port_arbiter.
//  Ports per requester x in {p, d}:
//    x_req, x_write, x_addr, x_data   requester -> arbiter
//    x_gnt, x_valid, x_rdata          arbiter -> requester
//  Memory side: mem_addr, mem_data, mem_wren (arbiter -> memory), mem_q (memory -> arbiter)
//  Status: busy, owner (0 = P, 1 = D)
//  Modports: master = requesters plus memory model, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          p_req;
    logic          p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          p_gnt;
    logic          p_valid;
    logic [DW-1:0] p_rdata;

    logic          d_req;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_data;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    logic          busy;
    logic          owner;

    modport master (
        output p_req, p_write, p_addr, p_data,
        output d_req, d_write, d_addr, d_data,
        output mem_q,
        input  p_gnt, p_valid, p_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  mem_addr, mem_data, mem_wren,
        input  busy, owner
    );

    modport slave (
        input  p_req, p_write, p_addr, p_data,
        input  d_req, d_write, d_addr, d_data,
        input  mem_q,
        output p_gnt, p_valid, p_rdata,
        output d_gnt, d_valid, d_rdata,
        output mem_addr, mem_data, mem_wren,
        output busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-port synchronous memory between the processor (P) and a
//  debug/loader port (D). Round-robin arbitration, one transaction at a time,
//  fixed IDLE -> ISSUE -> WAIT sequence (one transaction per 3 cycles).
//  Ports:
//    clk   system clock, all registers update on its rising edge
//    rst   synchronous active-high reset
//    bus   mem_port_arbiter_if.slave: requester handshakes, memory port, busy/owner
//  Timing: request seen in IDLE at T -> gnt at T+1 (ISSUE, memory address and
//  write enable presented), memory data returns in T+2 (WAIT), valid/rdata at
//  T+3, which is already an IDLE cycle able to arbitrate again.
module mem_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic          grant_s;
    logic          win_d_s;
    logic          win_write_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_data_s;

    logic          last_owner_r;
    logic          owner_r;
    logic          lat_write_r;
    logic          busy_r;
    logic          p_gnt_r;
    logic          d_gnt_r;
    logic          p_valid_r;
    logic          d_valid_r;
    logic          mem_wren_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_data_r;
    logic [DW-1:0] p_rdata_r;
    logic [DW-1:0] d_rdata_r;

    // Next-state and arbitration decision; a tie goes to the port that did not own last.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        win_d_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.p_req && bus.d_req) begin
                    grant_s = 1'b1;
                    win_d_s = ~last_owner_r;
                end else if (bus.p_req) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b0;
                end else if (bus.d_req) begin
                    grant_s = 1'b1;
                    win_d_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                    win_d_s = 1'b0;
                end
                if (grant_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Select the winning requester's command fields.
    always_comb begin
        win_write_s = 1'b0;
        win_addr_s  = {AW{1'b0}};
        win_data_s  = {DW{1'b0}};
        if (win_d_s) begin
            win_write_s = bus.d_write;
            win_addr_s  = bus.d_addr;
            win_data_s  = bus.d_data;
        end else begin
            win_write_s = bus.p_write;
            win_addr_s  = bus.p_addr;
            win_data_s  = bus.p_data;
        end
    end

    // State register and one-cycle handshake pulses (gnt in ISSUE, valid after WAIT).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            p_gnt_r    <= 1'b0;
            d_gnt_r    <= 1'b0;
            p_valid_r  <= 1'b0;
            d_valid_r  <= 1'b0;
            mem_wren_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            p_gnt_r    <= grant_s & ~win_d_s;
            d_gnt_r    <= grant_s & win_d_s;
            // Write enable exists only in the ISSUE cycle that follows a grant.
            mem_wren_r <= grant_s & win_write_s;
            p_valid_r  <= (state_r == ST_WAIT) & ~owner_r;
            d_valid_r  <= (state_r == ST_WAIT) & owner_r;
        end
    end

    // Latch the accepted transaction and ownership; held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            lat_write_r  <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_data_r   <= {DW{1'b0}};
        end else if (grant_s) begin
            owner_r      <= win_d_s;
            last_owner_r <= win_d_s;
            lat_write_r  <= win_write_s;
            mem_addr_r   <= win_addr_s;
            mem_data_r   <= win_data_s;
        end
    end

    // Capture read data at the end of WAIT; writes leave the owner's rdata untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_rdata_r <= {DW{1'b0}};
            d_rdata_r <= {DW{1'b0}};
        end else if ((state_r == ST_WAIT) && !lat_write_r) begin
            if (owner_r) begin
                d_rdata_r <= bus.mem_q;
            end else begin
                p_rdata_r <= bus.mem_q;
            end
        end
    end

    assign bus.p_gnt    = p_gnt_r;
    assign bus.d_gnt    = d_gnt_r;
    assign bus.p_valid  = p_valid_r;
    assign bus.d_valid  = d_valid_r;
    assign bus.p_rdata  = p_rdata_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_data = mem_data_r;
    assign bus.mem_wren = mem_wren_r;
    assign bus.busy     = busy_r;
    assign bus.owner    = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//  Directed bench for mem_port_arbiter. A transaction-level schedule model
//  predicts every output per cycle; a negedge process compares against it,
//  and the directed sequence adds hand-computed literal checks.
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int N  = 1024;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: synchronous write, registered read.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- schedule model ----------------
    bit            e_p_gnt [N];
    bit            e_d_gnt [N];
    bit            e_p_val [N];
    bit            e_d_val [N];
    bit            e_wren  [N];
    bit            e_busy  [N];
    bit            e_owner [N];
    logic [AW-1:0] e_maddr [N];
    logic [DW-1:0] e_mdata [N];
    logic [DW-1:0] e_p_rd  [N];
    logic [DW-1:0] e_d_rd  [N];
    logic [DW-1:0] mdl_mem [32];
    int            idle_from;
    bit            last_d;
    bit            model_live;

    // Each edge starts cycle cyc; inputs sampled here were those of cycle cyc-1.
    always @(posedge clk) begin
        bit            win_d;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cyc = cyc + 1;
        if (rst) begin
            model_live = 1'b1;
            idle_from  = cyc;
            last_d     = 1'b1;
            for (int k = cyc; k < N; k++) begin
                e_p_gnt[k] = 1'b0; e_d_gnt[k] = 1'b0; e_p_val[k] = 1'b0; e_d_val[k] = 1'b0;
                e_wren[k] = 1'b0; e_busy[k] = 1'b0; e_owner[k] = 1'b0;
                e_maddr[k] = '0; e_mdata[k] = '0; e_p_rd[k] = '0; e_d_rd[k] = '0;
            end
        end else if (model_live && (cyc - 1 >= idle_from) && (bus.p_req || bus.d_req) && (cyc + 2 < N)) begin
            if (bus.p_req && bus.d_req) win_d = !last_d;
            else                        win_d = bus.d_req;
            wr = win_d ? bus.d_write : bus.p_write;
            a  = win_d ? bus.d_addr  : bus.p_addr;
            d  = win_d ? bus.d_data  : bus.p_data;
            last_d    = win_d;
            idle_from = cyc + 2;
            if (win_d) begin e_d_gnt[cyc] = 1'b1; e_d_val[cyc+2] = 1'b1; end
            else       begin e_p_gnt[cyc] = 1'b1; e_p_val[cyc+2] = 1'b1; end
            e_busy[cyc]   = 1'b1;
            e_busy[cyc+1] = 1'b1;
            e_wren[cyc]   = wr;
            for (int k = cyc; k < N; k++) begin
                e_owner[k] = win_d; e_maddr[k] = a; e_mdata[k] = d;
            end
            if (wr) begin
                mdl_mem[a] = d;
            end else begin
                for (int k = cyc + 2; k < N; k++) begin
                    if (win_d) e_d_rd[k] = mdl_mem[a];
                    else       e_p_rd[k] = mdl_mem[a];
                end
            end
        end
    end

    // Compare every output against the model once the first reset has been seen.
    always @(negedge clk) begin
        if (model_live && cyc < N) begin
            chk("p_gnt",    32'(bus.p_gnt),    32'(e_p_gnt[cyc]));
            chk("d_gnt",    32'(bus.d_gnt),    32'(e_d_gnt[cyc]));
            chk("p_valid",  32'(bus.p_valid),  32'(e_p_val[cyc]));
            chk("d_valid",  32'(bus.d_valid),  32'(e_d_val[cyc]));
            chk("mem_wren", 32'(bus.mem_wren), 32'(e_wren[cyc]));
            chk("busy",     32'(bus.busy),     32'(e_busy[cyc]));
            chk("owner",    32'(bus.owner),    32'(e_owner[cyc]));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_maddr[cyc]));
            chk("mem_data", 32'(bus.mem_data), 32'(e_mdata[cyc]));
            chk("p_rdata",  32'(bus.p_rdata),  32'(e_p_rd[cyc]));
            chk("d_rdata",  32'(bus.d_rdata),  32'(e_d_rd[cyc]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // One transaction on one port; returns gnt and valid latency from the request cycle.
    task automatic xact(input bit dp, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gl, output int vl);
        int t0;
        t0 = cyc;
        gl = -1;
        vl = -1;
        if (dp) begin
            bus.d_write = wr; bus.d_addr = a; bus.d_data = d; bus.d_req = 1'b1;
        end else begin
            bus.p_write = wr; bus.p_addr = a; bus.p_data = d; bus.p_req = 1'b1;
        end
        for (int i = 0; i < 10 && gl < 0; i++) begin
            tick;
            if (dp ? bus.d_gnt : bus.p_gnt) gl = cyc - t0;
        end
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        for (int i = 0; i < 10 && vl < 0; i++) begin
            tick;
            if (dp ? bus.d_valid : bus.p_valid) vl = cyc - t0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl, vl, t0, pg, dg, ng, nw;
        bit po, dow;
        bit gseq [8];
        cyc = 0; checks = 0; errors = 0;
        idle_from = 0; last_d = 1'b1; model_live = 1'b0;
        for (int k = 0; k < 32; k++) begin ram[k] = '0; mdl_mem[k] = '0; end
        bus.p_req = 1'b0; bus.p_write = 1'b0; bus.p_addr = '0; bus.p_data = '0;
        bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_data = '0;

        // 1: two reset cycles -> everything zero
        do_reset;
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_owner", 32'(bus.owner),    32'd0);
        chk("rst_gnt",   32'({bus.p_gnt, bus.d_gnt, bus.p_valid, bus.d_valid}), 32'd0);
        chk("rst_wren",  32'(bus.mem_wren), 32'd0);
        chk("rst_maddr", 32'(bus.mem_addr), 32'd0);
        chk("rst_prd",   32'(bus.p_rdata),  32'd0);

        // 2: P write then read at address 5
        xact(1'b0, 1'b1, 5'd5, 16'hA5A5, gl, vl);
        chk("t2_wr_gnt_lat", 32'(gl), 32'd1);
        chk("t2_wr_val_lat", 32'(vl), 32'd3);
        xact(1'b0, 1'b0, 5'd5, 16'h0000, gl, vl);
        chk("t2_rd_gnt_lat", 32'(gl), 32'd1);
        chk("t2_rd_val_lat", 32'(vl), 32'd3);
        chk("t2_rdata",      32'(bus.p_rdata), 32'h0000A5A5);

        // 3: simultaneous requests straight after reset -> P first, D three cycles later
        do_reset;
        t0 = cyc; pg = -1; dg = -1; po = 1'b1; dow = 1'b0;
        bus.p_write = 1'b0; bus.p_addr = 5'd5; bus.p_req = 1'b1;
        bus.d_write = 1'b0; bus.d_addr = 5'd5; bus.d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.p_gnt && pg < 0) begin pg = cyc - t0; po = bus.owner; bus.p_req = 1'b0; end
            if (bus.d_gnt && dg < 0) begin dg = cyc - t0; dow = bus.owner; bus.d_req = 1'b0; end
        end
        chk("t3_p_gnt_at", 32'(pg),  32'd1);
        chk("t3_d_gnt_at", 32'(dg),  32'd4);
        chk("t3_owner_p",  32'(po),  32'd0);
        chk("t3_owner_d",  32'(dow), 32'd1);

        // 4: both held high 12 cycles -> P,D,P,D; P writes, D reads
        t0 = cyc; ng = 0; nw = 0;
        bus.p_write = 1'b1; bus.p_addr = 5'd3; bus.p_data = 16'h0F0F; bus.p_req = 1'b1;
        bus.d_write = 1'b0; bus.d_addr = 5'd5; bus.d_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (bus.mem_wren) nw++;
            if ((bus.p_gnt || bus.d_gnt) && ng < 8) begin gseq[ng] = bus.d_gnt; ng++; end
        end
        bus.p_req = 1'b0; bus.d_req = 1'b0;
        chk("t4_grants", 32'(ng), 32'd4);
        chk("t4_order",  32'({gseq[0], gseq[1], gseq[2], gseq[3]}), 32'b0101);
        chk("t4_wrens",  32'(nw), 32'd2);
        tick; tick;
        chk("t4_d_rdata", 32'(bus.d_rdata), 32'h0000A5A5);

        // 5: D writes the top address, P reads it back
        xact(1'b1, 1'b1, 5'd31, 16'h1234, gl, vl);
        chk("t5_d_val_lat", 32'(vl), 32'd3);
        xact(1'b0, 1'b0, 5'd31, 16'h0000, gl, vl);
        chk("t5_p_rdata",  32'(bus.p_rdata), 32'h00001234);
        chk("t5_d_hold",   32'(bus.d_rdata), 32'h0000A5A5);

        // 6: reset in the ISSUE cycle of a P write
        bus.p_write = 1'b1; bus.p_addr = 5'd7; bus.p_data = 16'hBEEF; bus.p_req = 1'b1;
        gl = -1;
        for (int i = 0; i < 10 && gl < 0; i++) begin
            tick;
            if (bus.p_gnt) gl = 1;
        end
        chk("t6_gnt_seen", 32'(gl), 32'd1);
        rst = 1'b1; bus.p_req = 1'b0;
        tick;
        rst = 1'b0;
        chk("t6_wren", 32'(bus.mem_wren), 32'd0);
        chk("t6_busy", 32'(bus.busy),     32'd0);
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.p_valid) nw++;
            tick;
        end
        chk("t6_no_valid", 32'(nw), 32'd0);
        xact(1'b0, 1'b0, 5'd5, 16'h0000, gl, vl);
        chk("t6_recover_lat", 32'(vl), 32'd3);
        chk("t6_recover_rd",  32'(bus.p_rdata), 32'h0000A5A5);

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
